// File: rtl/fust_s_issue_ctrl_pkg.sv
// Shared types for the scalar FUST scheduler: row states, row payload, table view
// and the producer-tag helper.
package fust_s_issue_ctrl_pkg;

  localparam int unsigned S_ROWS = 3;
  localparam int unsigned FU_S_W = 2;
  localparam int unsigned TAG_W  = FU_S_W;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned REG_W  = 5;

  typedef logic [FU_S_W-1:0] fu_scalar_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [2:0] {
    FUST_EMPTY = 3'd0,
    FUST_WAIT  = 3'd1,
    FUST_RDY   = 3'd2,
    FUST_EX    = 3'd3
  } fust_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    tag_t             t1;
    tag_t             t2;
  } fust_s_row_t;

  typedef struct packed {
    logic [S_ROWS-1:0]        busy;
    fust_s_row_t [S_ROWS-1:0] rows;
  } fust_s_t;

  // Tag value 0 means "operand ready", so row k is named by tag k+1.
  function automatic tag_t tag_of(fu_scalar_t fu);
    return TAG_W'(fu + 2'd1);
  endfunction

endpackage

// File: rtl/fust_s_issue_ctrl_if.sv
// Dispatch-in / issue-out handshake bundle of the scalar FUST scheduler.
interface fust_s_issue_ctrl_if;
  import fust_s_issue_ctrl_pkg::*;

  logic        disp_valid;
  fu_scalar_t  disp_fu;
  fust_s_row_t disp_row;
  logic        disp_ready;
  logic        issue_valid;
  fu_scalar_t  issue_fu;
  fust_s_row_t issue_row;
  logic        issue_ready;

  modport master (
    output disp_valid, disp_fu, disp_row, issue_ready,
    input  disp_ready, issue_valid, issue_fu, issue_row
  );

  modport slave (
    input  disp_valid, disp_fu, disp_row, issue_ready,
    output disp_ready, issue_valid, issue_fu, issue_row
  );

endinterface

// File: rtl/fust_s_issue_ctrl_rr_arb3.sv
// Three-way round-robin pick: first requester at or after ptr, wrapping mod 3.
module fust_s_issue_ctrl_rr_arb3
  import fust_s_issue_ctrl_pkg::*;
(
  input  logic [S_ROWS-1:0] req_i,
  input  fu_scalar_t        ptr_i,
  output logic [S_ROWS-1:0] gnt_c_o,
  output fu_scalar_t        gnt_idx_c_o
);

  fu_scalar_t idx;

  always_comb begin
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    idx         = '0;
    for (int unsigned i = 0; i < S_ROWS; i++) begin
      idx = FU_S_W'((32'(ptr_i) + i) % S_ROWS);
      if (gnt_c_o == '0 && req_i[idx]) begin
        gnt_c_o[idx] = 1'b1;
        gnt_idx_c_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fust_s_issue_ctrl.sv
// Scalar FUST scheduler: per-row EMPTY/WAIT/RDY/EX tracking, tag wakeup on FU
// completion, round-robin issue with offer locking, and flush.
module fust_s_issue_ctrl
  import fust_s_issue_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [S_ROWS-1:0]         fu_done_i,
  output logic [S_ROWS-1:0]         wb_tag_vld_o,
  output fust_s_t                   fust_o,
  output fust_state_e [S_ROWS-1:0]  row_state_o,
  fust_s_issue_ctrl_if.slave        bus
);

  fust_state_e [S_ROWS-1:0] state_q, state_d;
  fust_s_row_t [S_ROWS-1:0] row_q, row_d;
  fu_scalar_t               rr_ptr_q, rr_ptr_d;
  logic                     hold_q, hold_d;
  fu_scalar_t               hold_idx_q, hold_idx_d;
  logic [S_ROWS-1:0]        wb_q;

  logic [S_ROWS-1:0] done_eff, rdy_req, arb_gnt;
  fu_scalar_t        arb_idx, sel_idx;
  fust_s_row_t       disp_entry;
  logic              disp_hs, issue_hs;

  function automatic tag_t clr_tag(tag_t t, logic [S_ROWS-1:0] done);
    tag_t r;
    r = t;
    for (int unsigned k = 0; k < S_ROWS; k++) begin
      if (done[k] && t == tag_of(FU_S_W'(k))) r = '0;
    end
    return r;
  endfunction

  // Completion only counts for a row actually executing.
  always_comb begin
    done_eff = '0;
    rdy_req  = '0;
    for (int unsigned k = 0; k < S_ROWS; k++) begin
      done_eff[k] = fu_done_i[k] && (state_q[k] == FUST_EX);
      rdy_req[k]  = (state_q[k] == FUST_RDY);
    end
  end

  fust_s_issue_ctrl_rr_arb3 u_arb (
    .req_i       (rdy_req),
    .ptr_i       (rr_ptr_q),
    .gnt_c_o     (arb_gnt),
    .gnt_idx_c_o (arb_idx)
  );

  // A stalled offer stays locked so a newly ready row cannot displace it.
  always_comb begin
    sel_idx         = hold_q ? hold_idx_q : arb_idx;
    bus.issue_valid = !flush_i && (hold_q || (arb_gnt != '0));
    bus.issue_fu    = sel_idx;
    bus.issue_row   = '0;
    bus.disp_ready  = 1'b0;
    for (int unsigned k = 0; k < S_ROWS; k++) begin
      if (sel_idx == FU_S_W'(k)) bus.issue_row = row_q[k];
      if (bus.disp_fu == FU_S_W'(k) && state_q[k] == FUST_EMPTY) bus.disp_ready = !flush_i;
    end
    bus.issue_row.t1 = '0;
    bus.issue_row.t2 = '0;
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    rr_ptr_d      = rr_ptr_q;
    hold_d        = 1'b0;
    hold_idx_d    = hold_idx_q;
    disp_hs       = bus.disp_valid && bus.disp_ready;
    issue_hs      = bus.issue_valid && bus.issue_ready;
    disp_entry    = bus.disp_row;
    disp_entry.t1 = clr_tag(bus.disp_row.t1, done_eff);
    disp_entry.t2 = clr_tag(bus.disp_row.t2, done_eff);
    if (bus.issue_valid && !bus.issue_ready) begin
      hold_d     = 1'b1;
      hold_idx_d = sel_idx;
    end
    for (int unsigned k = 0; k < S_ROWS; k++) begin
      row_d[k].t1 = clr_tag(row_q[k].t1, done_eff);
      row_d[k].t2 = clr_tag(row_q[k].t2, done_eff);
      case (state_q[k])
        FUST_WAIT: if (row_d[k].t1 == '0 && row_d[k].t2 == '0) state_d[k] = FUST_RDY;
        FUST_EX: begin
          if (done_eff[k]) begin
            state_d[k] = FUST_EMPTY;
            row_d[k]   = '0;
          end
        end
        default: ;
      endcase
      if (flush_i && (state_q[k] == FUST_WAIT || state_q[k] == FUST_RDY)) begin
        state_d[k] = FUST_EMPTY;
        row_d[k]   = '0;
      end
      if (issue_hs && sel_idx == FU_S_W'(k)) begin
        state_d[k] = FUST_EX;
        rr_ptr_d   = FU_S_W'((k + 1) % S_ROWS);
      end
      if (disp_hs && bus.disp_fu == FU_S_W'(k)) begin
        row_d[k]   = disp_entry;
        state_d[k] = (disp_entry.t1 == '0 && disp_entry.t2 == '0) ? FUST_RDY : FUST_WAIT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < S_ROWS; k++) state_q[k] <= FUST_EMPTY;
      row_q      <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      wb_q       <= fu_done_i;
    end
  end

  always_comb begin
    fust_o.busy = '0;
    fust_o.rows = row_q;
    for (int unsigned k = 0; k < S_ROWS; k++) fust_o.busy[k] = (state_q[k] != FUST_EMPTY);
  end

  assign wb_tag_vld_o = wb_q;
  assign row_state_o  = state_q;

endmodule

// File: tb/tb_fust_s_issue_ctrl.sv
// Bench for the scalar FUST scheduler: directed scenarios plus a randomized run
// against a queue-free array model of the row rules.
module tb_fust_s_issue_ctrl;
  import fust_s_issue_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     flush = 1'b0;
  logic [2:0]               fu_done = '0;
  logic [2:0]               wb;
  fust_s_t                  fust;
  fust_state_e [2:0]        rs;

  fust_s_issue_ctrl_if bus ();

  fust_s_issue_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .fu_done_i    (fu_done),
    .wb_tag_vld_o (wb),
    .fust_o       (fust),
    .row_state_o  (rs),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int ME = 0, MW = 1, MR = 2, MX = 3;
  int          m_st[3];
  fust_s_row_t m_row[3];
  int          m_rr;
  int          m_lock;
  logic [2:0]  m_wb;

  function automatic fust_s_row_t mkrow(logic [7:0] op, int t1, int t2);
    fust_s_row_t r;
    r.op = op;
    r.rd = op[4:0];
    r.t1 = 2'(t1);
    r.t2 = 2'(t2);
    return r;
  endfunction

  function automatic fust_state_e st_enum(int s);
    case (s)
      MW:      return FUST_WAIT;
      MR:      return FUST_RDY;
      MX:      return FUST_EX;
      default: return FUST_EMPTY;
    endcase
  endfunction

  function automatic logic [1:0] wake(logic [1:0] t, logic [2:0] d);
    if (t != 0 && d[int'(t) - 1]) return 2'd0;
    return t;
  endfunction

  function automatic int m_sel();
    if (flush) return -1;
    if (m_lock >= 0) return m_lock;
    for (int i = 0; i < 3; i++) if (m_st[(m_rr + i) % 3] == MR) return (m_rr + i) % 3;
    return -1;
  endfunction

  function automatic bit m_disp_ready();
    int f;
    f = int'(bus.disp_fu);
    if (f == 3 || flush) return 1'b0;
    return m_st[f] == ME;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k]  = ME;
      m_row[k] = '0;
    end
    m_rr   = 0;
    m_lock = -1;
    m_wb   = '0;
  endtask

  task automatic model_step();
    int sel;
    bit dr;
    logic [2:0] d;
    int nst[3];
    fust_s_row_t nrow[3];
    fust_s_row_t r;
    sel = m_sel();
    dr  = m_disp_ready();
    for (int k = 0; k < 3; k++) d[k] = fu_done[k] && m_st[k] == MX;
    for (int k = 0; k < 3; k++) begin
      nst[k]  = d[k] ? ME : m_st[k];
      nrow[k] = d[k] ? '0 : m_row[k];
      nrow[k].t1 = wake(nrow[k].t1, d);
      nrow[k].t2 = wake(nrow[k].t2, d);
      if (nst[k] == MW && nrow[k].t1 == 0 && nrow[k].t2 == 0) nst[k] = MR;
    end
    if (flush) begin
      for (int k = 0; k < 3; k++) if (m_st[k] == MW || m_st[k] == MR) begin
        nst[k]  = ME;
        nrow[k] = '0;
      end
      m_lock = -1;
    end else begin
      if (sel >= 0 && bus.issue_ready) begin
        nst[sel] = MX;
        m_rr     = (sel + 1) % 3;
        m_lock   = -1;
      end else begin
        m_lock = sel;
      end
      if (bus.disp_valid && dr) begin
        r    = bus.disp_row;
        r.t1 = wake(r.t1, d);
        r.t2 = wake(r.t2, d);
        nst[int'(bus.disp_fu)]  = (r.t1 == 0 && r.t2 == 0) ? MR : MW;
        nrow[int'(bus.disp_fu)] = r;
      end
    end
    for (int k = 0; k < 3; k++) begin
      m_st[k]  = nst[k];
      m_row[k] = nrow[k];
    end
    m_wb = fu_done;
  endtask

  task automatic drive(bit dv, int fu, fust_s_row_t r, bit ir, logic [2:0] fd, bit fl);
    bus.disp_valid  = dv;
    bus.disp_fu     = 2'(fu);
    bus.disp_row    = r;
    bus.issue_ready = ir;
    fu_done         = fd;
    flush           = fl;
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 3'b000, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (rs !== 9'd0) begin bad++; $display("FAIL reset_state got=%h exp=0", rs); end
    total++; if (fust !== '0) begin bad++; $display("FAIL reset_fust got=%h exp=0", fust); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_ivalid got=%b exp=0", bus.issue_valid); end
    total++; if (wb !== 3'b000) begin bad++; $display("FAIL reset_wb got=%b exp=000", wb); end
    total++; if (bus.disp_ready !== 1'b1) begin bad++; $display("FAIL reset_dready got=%b exp=1", bus.disp_ready); end
    bus.disp_fu = 2'd3;
    #1;
    total++; if (bus.disp_ready !== 1'b0) begin bad++; $display("FAIL illegal_fu_dready got=%b exp=0", bus.disp_ready); end
  endtask

  task automatic test_alu_issue();
    do_reset();
    drive(1, 0, mkrow(8'hA5, 0, 0), 0, 3'b000, 0);
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[0] !== FUST_RDY) begin bad++; $display("FAIL alu_rdy got=%0d exp=%0d", rs[0], FUST_RDY); end
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 2'd0) begin
      bad++; $display("FAIL alu_issue got=%b/%0d exp=1/0", bus.issue_valid, bus.issue_fu); end
    total++; if (bus.issue_row !== mkrow(8'hA5, 0, 0)) begin
      bad++; $display("FAIL alu_row got=%h exp=%h", bus.issue_row, mkrow(8'hA5, 0, 0)); end
  endtask

  task automatic test_wakeup();
    do_reset();
    drive(1, 0, mkrow(8'h01, 0, 0), 1, 3'b000, 0);
    adv();
    drive(0, 0, '0, 1, 3'b000, 0);
    adv();
    drive(1, 2, mkrow(8'h22, 1, 0), 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[0] !== FUST_EX) begin bad++; $display("FAIL wk_alu_ex got=%0d exp=%0d", rs[0], FUST_EX); end
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[2] !== FUST_WAIT || bus.issue_valid !== 1'b0) begin
      bad++; $display("FAIL wk_br_wait got=%0d/%b exp=%0d/0", rs[2], bus.issue_valid, FUST_WAIT); end
    fu_done = 3'b001;
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[2] !== FUST_RDY || rs[0] !== FUST_EMPTY) begin
      bad++; $display("FAIL wk_states got=%0d/%0d exp=%0d/%0d", rs[2], rs[0], FUST_RDY, FUST_EMPTY); end
    total++; if (wb !== 3'b001) begin bad++; $display("FAIL wk_wb got=%b exp=001", wb); end
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 2'd2) begin
      bad++; $display("FAIL wk_issue got=%b/%0d exp=1/2", bus.issue_valid, bus.issue_fu); end
    adv();
    @(negedge clk);
    total++; if (wb !== 3'b000) begin bad++; $display("FAIL wk_wb_pulse got=%b exp=000", wb); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 0, mkrow(8'h03, 0, 0), 1, 3'b000, 0);
    adv();
    drive(0, 0, '0, 1, 3'b000, 0);
    adv();
    drive(1, 1, mkrow(8'h33, 0, 1), 0, 3'b001, 0);
    @(negedge clk);
    total++; if (bus.disp_ready !== 1'b1) begin bad++; $display("FAIL sc_dready got=%b exp=1", bus.disp_ready); end
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[1] !== FUST_RDY || rs[0] !== FUST_EMPTY) begin
      bad++; $display("FAIL sc_states got=%0d/%0d exp=%0d/%0d", rs[1], rs[0], FUST_RDY, FUST_EMPTY); end
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 2'd1 || bus.issue_row.t2 !== 2'd0) begin
      bad++; $display("FAIL sc_issue got=%b/%0d/%0d exp=1/1/0", bus.issue_valid, bus.issue_fu, bus.issue_row.t2); end
  endtask

  task automatic test_rr_order();
    int exp_a[3] = '{0, 1, 2};
    int exp_b[3] = '{2, 0, 1};
    do_reset();
    for (int f = 0; f < 3; f++) begin
      drive(1, f, mkrow(8'(8'h40 + f), 0, 0), 0, 3'b000, 0);
      adv();
    end
    drive(0, 0, '0, 1, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || int'(bus.issue_fu) != exp_a[i]) begin
        bad++; $display("FAIL rr_a%0d got=%b/%0d exp=1/%0d", i, bus.issue_valid, bus.issue_fu, exp_a[i]); end
      adv();
    end
    do_reset();
    drive(1, 1, mkrow(8'h50, 0, 0), 1, 3'b000, 0);
    adv();
    drive(0, 0, '0, 1, 3'b000, 0);
    adv();
    drive(1, 0, mkrow(8'h51, 2, 0), 0, 3'b000, 0);
    adv();
    drive(1, 2, mkrow(8'h52, 2, 0), 0, 3'b000, 0);
    adv();
    drive(0, 0, '0, 0, 3'b010, 0);
    adv();
    drive(1, 1, mkrow(8'h53, 0, 0), 0, 3'b000, 0);
    adv();
    drive(0, 0, '0, 1, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || int'(bus.issue_fu) != exp_b[i]) begin
        bad++; $display("FAIL rr_b%0d got=%b/%0d exp=1/%0d", i, bus.issue_valid, bus.issue_fu, exp_b[i]); end
      adv();
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, 2, mkrow(8'h77, 0, 0), 0, 3'b000, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, mkrow(8'h78, 0, 0), 0, 3'b000, 0);
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 2'd2 || bus.issue_row.op !== 8'h77) begin
        bad++; $display("FAIL hold%0d got=%b/%0d/%h exp=1/2/77", i, bus.issue_valid, bus.issue_fu, bus.issue_row.op); end
      total++; if (bus.disp_ready !== 1'b0) begin bad++; $display("FAIL hold_dready%0d got=%b exp=0", i, bus.disp_ready); end
      adv();
    end
    drive(1, 0, mkrow(8'h79, 0, 0), 0, 3'b000, 0);
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs[0] !== FUST_RDY || bus.issue_fu !== 2'd2) begin
      bad++; $display("FAIL hold_lock got=%0d/%0d exp=%0d/2", rs[0], bus.issue_fu, FUST_RDY); end
    bus.issue_ready = 1'b1;
    adv();
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 2'd0 || rs[2] !== FUST_EX) begin
      bad++; $display("FAIL hold_next got=%b/%0d/%0d exp=1/0/%0d", bus.issue_valid, bus.issue_fu, rs[2], FUST_EX); end
  endtask

  task automatic build_scene();
    do_reset();
    drive(1, 0, mkrow(8'h01, 0, 0), 1, 3'b000, 0);
    adv();
    drive(0, 0, '0, 1, 3'b000, 0);
    adv();
    drive(1, 1, mkrow(8'h02, 1, 0), 0, 3'b000, 0);
    adv();
    drive(1, 2, mkrow(8'h03, 0, 0), 0, 3'b000, 0);
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
  endtask

  task automatic test_flush();
    fust_state_e [2:0] e;
    build_scene();
    @(negedge clk);
    e[0] = FUST_EX; e[1] = FUST_WAIT; e[2] = FUST_RDY;
    total++; if (rs !== e) begin bad++; $display("FAIL fl_scene got=%h exp=%h", rs, e); end
    drive(1, 1, mkrow(8'h09, 0, 0), 1, 3'b000, 1);
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b0 || bus.disp_ready !== 1'b0) begin
      bad++; $display("FAIL fl_block got=%b/%b exp=0/0", bus.issue_valid, bus.disp_ready); end
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    e[0] = FUST_EX; e[1] = FUST_EMPTY; e[2] = FUST_EMPTY;
    total++; if (rs !== e || bus.issue_valid !== 1'b0) begin
      bad++; $display("FAIL fl_after got=%h/%b exp=%h/0", rs, bus.issue_valid, e); end
    fu_done = 3'b001;
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs !== 9'd0) begin bad++; $display("FAIL fl_done got=%h exp=0", rs); end
    build_scene();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (rs !== 9'd0 || fust !== '0) begin bad++; $display("FAIL rst_mid got=%h/%h exp=0/0", rs, fust); end
    fu_done = 3'b001;
    adv();
    drive(0, 0, '0, 0, 3'b000, 0);
    @(negedge clk);
    total++; if (rs !== 9'd0 || bus.issue_valid !== 1'b0) begin
      bad++; $display("FAIL rst_late_done got=%h/%b exp=0/0", rs, bus.issue_valid); end
  endtask

  task automatic test_random();
    int sel;
    fust_s_t ef;
    fust_s_row_t er;
    fust_state_e [2:0] es;
    logic [2:0] fd;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) fd[k] = (m_st[k] == MX) && ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 3)),
            mkrow(8'($urandom), $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3)),
                  $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3))),
            $urandom_range(0, 9) < 6, fd, $urandom_range(0, 39) == 0);
      @(negedge clk);
      sel = m_sel();
      for (int k = 0; k < 3; k++) begin
        es[k]      = st_enum(m_st[k]);
        ef.busy[k] = m_st[k] != ME;
        ef.rows[k] = m_row[k];
      end
      total++; if (bus.disp_ready !== m_disp_ready()) begin
        bad++; $display("FAIL rnd_dready n=%0d got=%b exp=%b", n, bus.disp_ready, m_disp_ready()); end
      total++; if (bus.issue_valid !== (sel >= 0)) begin
        bad++; $display("FAIL rnd_ivalid n=%0d got=%b exp=%b", n, bus.issue_valid, sel >= 0); end
      if (sel >= 0) begin
        er = m_row[sel];
        er.t1 = 2'd0;
        er.t2 = 2'd0;
        total++; if (int'(bus.issue_fu) != sel || bus.issue_row !== er) begin
          bad++; $display("FAIL rnd_issue n=%0d got=%0d/%h exp=%0d/%h", n, bus.issue_fu, bus.issue_row, sel, er); end
      end
      total++; if (rs !== es) begin bad++; $display("FAIL rnd_state n=%0d got=%h exp=%h", n, rs, es); end
      total++; if (fust !== ef) begin bad++; $display("FAIL rnd_fust n=%0d got=%h exp=%h", n, fust, ef); end
      total++; if (wb !== m_wb) begin bad++; $display("FAIL rnd_wb n=%0d got=%b exp=%b", n, wb, m_wb); end
      adv();
    end
  endtask

  initial begin
    drive(0, 0, '0, 0, 3'b000, 0);
    model_reset();
    test_reset();
    test_alu_issue();
    test_wakeup();
    test_same_cycle();
    test_rr_order();
    test_hold();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
